// File: rtl/hazard_unit_mc.sv
// Hazard detection for the instruction in ID: freezes PC and IF/ID and bubbles ID/EX for N cycles.
// Response is combinational (0 cycles); a down-counter holds the remaining bubbles after detection.
module hazard_unit_mc #(
   parameter int REG_ADDR_W             = 5,
   parameter int CNT_W                  = 2,
   parameter int LOAD_USE_STALLS        = 1,
   parameter int ALU_BRANCH_STALLS      = 1,
   parameter int LOAD_BRANCH_STALLS     = 2,
   parameter int MEM_LOAD_BRANCH_STALLS = 1,
   parameter int ZERO_REG_EXEMPT        = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rs,
   input  logic                  id_uses_rt,
   input  logic                  id_branch,
   input  logic                  id_branch_taken,
   input  logic                  ex_mem_read,
   input  logic                  ex_reg_write,
   input  logic [REG_ADDR_W-1:0] ex_dst,
   input  logic                  mem_mem_read,
   input  logic [REG_ADDR_W-1:0] mem_dst,
   output logic                  pc_write,
   output logic                  ifid_write,
   output logic                  idex_bubble,
   output logic                  ifid_flush,
   output logic                  stall_active,
   output logic [CNT_W-1:0]      stall_remaining
);

   typedef enum logic {IDLE = 1'b0, STALL = 1'b1} state_t;

   localparam logic [CNT_W-1:0] LU_N = CNT_W'(LOAD_USE_STALLS);
   localparam logic [CNT_W-1:0] AB_N = CNT_W'(ALU_BRANCH_STALLS);
   localparam logic [CNT_W-1:0] LB_N = CNT_W'(LOAD_BRANCH_STALLS);
   localparam logic [CNT_W-1:0] MB_N = CNT_W'(MEM_LOAD_BRANCH_STALLS);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   state_t           state;
   logic [CNT_W-1:0] r_q, r_d, n;
   logic             det;
   logic             ex_src_hit, mem_src_hit;
   logic             lb_hit, lu_hit, ab_hit, mb_hit;

   function automatic logic match_f(input logic [REG_ADDR_W-1:0] a,
                                    input logic [REG_ADDR_W-1:0] x);
      return (a == x) && !((ZERO_REG_EXEMPT != 0) && (x == '0));
   endfunction

   // Uses flags gate the compares so stale fields in unused slots never stall.
   assign ex_src_hit  = (id_uses_rs && match_f(id_rs, ex_dst)) ||
                        (id_uses_rt && match_f(id_rt, ex_dst));
   assign mem_src_hit = (id_uses_rs && match_f(id_rs, mem_dst)) ||
                        (id_uses_rt && match_f(id_rt, mem_dst));

   assign lb_hit = id_branch && ex_mem_read && ex_src_hit;
   assign lu_hit = ex_mem_read && ex_src_hit;
   assign ab_hit = id_branch && ex_reg_write && !ex_mem_read && ex_src_hit;
   assign mb_hit = id_branch && mem_mem_read && mem_src_hit;

   // A hit whose bubble count is zero falls through to the next check.
   always_comb begin
      det = 1'b0;
      n   = '0;
      if (!rst) begin
         if (lb_hit && (LB_N != '0)) begin
            det = 1'b1;
            n   = LB_N;
         end else if (lu_hit && (LU_N != '0)) begin
            det = 1'b1;
            n   = LU_N;
         end else if (ab_hit && (AB_N != '0)) begin
            det = 1'b1;
            n   = AB_N;
         end else if (mb_hit && (MB_N != '0)) begin
            det = 1'b1;
            n   = MB_N;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_q <= '0;
      else     r_q <= r_d;
   end

   always_comb begin
      state        = (r_q != '0) ? STALL : IDLE;
      r_d          = '0;
      stall_active = 1'b0;
      case (state)
         STALL: begin
            r_d          = r_q - ONE;
            stall_active = 1'b1;
         end
         IDLE: begin
            if (det) begin
               r_d          = n - ONE;
               stall_active = 1'b1;
            end
         end
         default: ;
      endcase
      pc_write        = !stall_active;
      ifid_write      = !stall_active;
      idex_bubble     = stall_active;
      ifid_flush      = id_branch && id_branch_taken && !stall_active;
      stall_remaining = r_d;
   end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc: default, zero-reg-not-exempt and swept-parameter instances share stimulus.
module tb_hazard_unit_mc;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [4:0] id_rs, id_rt, ex_dst, mem_dst;
   logic       id_uses_rs, id_uses_rt, id_branch, id_branch_taken;
   logic       ex_mem_read, ex_reg_write, mem_mem_read;

   logic       pw0, iw0, bub0, fl0, sa0;
   logic       pw1, iw1, bub1, fl1, sa1;
   logic       pw2, iw2, bub2, fl2, sa2;
   logic [1:0] sr0, sr1, sr2;
   logic [6:0] o0, o1, o2;

   int n_cmp = 0;
   int n_bad = 0;

   // Output vector order: pc_write, ifid_write, idex_bubble, ifid_flush, stall_active, stall_remaining[1:0]
   localparam logic [6:0] IDLE_V  = 7'b1100000;
   localparam logic [6:0] FLUSH_V = 7'b1101000;
   localparam logic [6:0] S0      = 7'b0010100;
   localparam logic [6:0] S1      = 7'b0010101;
   localparam logic [6:0] S2      = 7'b0010110;

   assign o0 = {pw0, iw0, bub0, fl0, sa0, sr0};
   assign o1 = {pw1, iw1, bub1, fl1, sa1, sr1};
   assign o2 = {pw2, iw2, bub2, fl2, sa2, sr2};

   always #5 clk = ~clk;

   hazard_unit_mc dut0 (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_branch(id_branch), .id_branch_taken(id_branch_taken),
      .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_dst(ex_dst),
      .mem_mem_read(mem_mem_read), .mem_dst(mem_dst),
      .pc_write(pw0), .ifid_write(iw0), .idex_bubble(bub0), .ifid_flush(fl0),
      .stall_active(sa0), .stall_remaining(sr0));

   hazard_unit_mc #(.ZERO_REG_EXEMPT(0)) dut1 (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_branch(id_branch), .id_branch_taken(id_branch_taken),
      .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_dst(ex_dst),
      .mem_mem_read(mem_mem_read), .mem_dst(mem_dst),
      .pc_write(pw1), .ifid_write(iw1), .idex_bubble(bub1), .ifid_flush(fl1),
      .stall_active(sa1), .stall_remaining(sr1));

   hazard_unit_mc #(.LOAD_BRANCH_STALLS(3), .LOAD_USE_STALLS(0)) dut2 (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_branch(id_branch), .id_branch_taken(id_branch_taken),
      .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_dst(ex_dst),
      .mem_mem_read(mem_mem_read), .mem_dst(mem_dst),
      .pc_write(pw2), .ifid_write(iw2), .idex_bubble(bub2), .ifid_flush(fl2),
      .stall_active(sa2), .stall_remaining(sr2));

   task automatic clear_inputs();
      id_rs = '0; id_rt = '0; ex_dst = '0; mem_dst = '0;
      id_uses_rs = 0; id_uses_rt = 0; id_branch = 0; id_branch_taken = 0;
      ex_mem_read = 0; ex_reg_write = 0; mem_mem_read = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      #2 rst = 1'b1;
      #1;
      if (o0 !== IDLE_V) begin n_bad++; $display("FAIL rst_idle dut0: got %b want %b", o0, IDLE_V); end n_cmp++;
      if (o2 !== IDLE_V) begin n_bad++; $display("FAIL rst_idle dut2: got %b want %b", o2, IDLE_V); end n_cmp++;
      ex_mem_read = 1; ex_dst = 5'd8; id_rs = 5'd8; id_uses_rs = 1;
      #1;
      if (o0 !== IDLE_V) begin n_bad++; $display("FAIL rst_hazard dut0: got %b want %b", o0, IDLE_V); end n_cmp++;
      @(posedge clk);
      @(negedge clk);
      clear_inputs();
      rst = 1'b0;
      #1;
      if (o1 !== IDLE_V) begin n_bad++; $display("FAIL rst_release dut1: got %b want %b", o1, IDLE_V); end n_cmp++;
   endtask

   task automatic test_load_use();
      @(negedge clk);
      clear_inputs();
      ex_mem_read = 1; ex_dst = 5'd8; id_rs = 5'd8; id_uses_rs = 1;
      #1;
      if (o0 !== S0)     begin n_bad++; $display("FAIL lu_c1 dut0: got %b want %b", o0, S0); end n_cmp++;
      if (o1 !== S0)     begin n_bad++; $display("FAIL lu_c1 dut1: got %b want %b", o1, S0); end n_cmp++;
      if (o2 !== IDLE_V) begin n_bad++; $display("FAIL lu_disabled dut2: got %b want %b", o2, IDLE_V); end n_cmp++;
      @(negedge clk);
      ex_mem_read = 0; ex_dst = '0;
      #1;
      if (o0 !== IDLE_V) begin n_bad++; $display("FAIL lu_c2 dut0: got %b want %b", o0, IDLE_V); end n_cmp++;
   endtask

   task automatic test_load_branch();
      @(negedge clk);
      clear_inputs();
      id_branch = 1; id_branch_taken = 1; id_uses_rt = 1; id_rt = 5'd9;
      ex_mem_read = 1; ex_dst = 5'd9;
      #1;
      if (o0 !== S1) begin n_bad++; $display("FAIL lb_c1 dut0: got %b want %b", o0, S1); end n_cmp++;
      if (o2 !== S2) begin n_bad++; $display("FAIL lb3_c1 dut2: got %b want %b", o2, S2); end n_cmp++;
      @(negedge clk);
      ex_mem_read = 0; ex_dst = '0; mem_mem_read = 1; mem_dst = 5'd9;
      #1;
      if (o0 !== S0) begin n_bad++; $display("FAIL lb_c2 dut0: got %b want %b", o0, S0); end n_cmp++;
      if (o2 !== S1) begin n_bad++; $display("FAIL lb3_c2 dut2: got %b want %b", o2, S1); end n_cmp++;
      @(negedge clk);
      mem_mem_read = 0; mem_dst = '0;
      #1;
      if (o0 !== FLUSH_V) begin n_bad++; $display("FAIL lb_flush dut0: got %b want %b", o0, FLUSH_V); end n_cmp++;
      if (o2 !== S0)      begin n_bad++; $display("FAIL lb3_c3 dut2: got %b want %b", o2, S0); end n_cmp++;
      @(negedge clk);
      #1;
      if (o2 !== FLUSH_V) begin n_bad++; $display("FAIL lb3_flush dut2: got %b want %b", o2, FLUSH_V); end n_cmp++;
   endtask

   task automatic test_alu_mem_branch();
      @(negedge clk);
      clear_inputs();
      id_branch = 1; id_uses_rs = 1; id_rs = 5'd4; ex_reg_write = 1; ex_dst = 5'd4;
      #1;
      if (o0 !== S0) begin n_bad++; $display("FAIL ab dut0: got %b want %b", o0, S0); end n_cmp++;
      if (o2 !== S0) begin n_bad++; $display("FAIL ab dut2: got %b want %b", o2, S0); end n_cmp++;
      @(negedge clk);
      ex_reg_write = 0; ex_dst = '0; mem_mem_read = 1; mem_dst = 5'd4;
      #1;
      if (o0 !== S0) begin n_bad++; $display("FAIL mb dut0: got %b want %b", o0, S0); end n_cmp++;
      if (o2 !== S0) begin n_bad++; $display("FAIL mb dut2: got %b want %b", o2, S0); end n_cmp++;
      @(negedge clk);
      mem_mem_read = 0; mem_dst = '0;
      #1;
      if (o0 !== IDLE_V) begin n_bad++; $display("FAIL mb_done dut0: got %b want %b", o0, IDLE_V); end n_cmp++;
      @(negedge clk);
      id_rs = '0; ex_reg_write = 1; ex_dst = '0;
      #1;
      if (o0 !== IDLE_V) begin n_bad++; $display("FAIL ab_zero dut0: got %b want %b", o0, IDLE_V); end n_cmp++;
      if (o1 !== S0)     begin n_bad++; $display("FAIL ab_zero dut1: got %b want %b", o1, S0); end n_cmp++;
      @(negedge clk);
      ex_reg_write = 0; mem_mem_read = 1; mem_dst = '0;
      #1;
      if (o0 !== IDLE_V) begin n_bad++; $display("FAIL mb_zero dut0: got %b want %b", o0, IDLE_V); end n_cmp++;
      if (o1 !== S0)     begin n_bad++; $display("FAIL mb_zero dut1: got %b want %b", o1, S0); end n_cmp++;
   endtask

   task automatic test_unused_source();
      @(negedge clk);
      clear_inputs();
      id_rs = 5'd5; id_rt = 5'd5; ex_mem_read = 1; ex_dst = 5'd5;
      id_branch = 1; id_branch_taken = 1; mem_mem_read = 1; mem_dst = 5'd5;
      #1;
      if (o0 !== FLUSH_V) begin n_bad++; $display("FAIL unused dut0: got %b want %b", o0, FLUSH_V); end n_cmp++;
      if (o2 !== FLUSH_V) begin n_bad++; $display("FAIL unused dut2: got %b want %b", o2, FLUSH_V); end n_cmp++;
      @(negedge clk);
      id_branch = 0; id_branch_taken = 0; mem_mem_read = 0; id_uses_rt = 1;
      #1;
      if (o0 !== S0) begin n_bad++; $display("FAIL used_rt dut0: got %b want %b", o0, S0); end n_cmp++;
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      clear_inputs();
      ex_mem_read = 1; ex_dst = 5'd8; id_rs = 5'd8; id_uses_rs = 1;
      #1;
      if (o0 !== S0) begin n_bad++; $display("FAIL b2b_lu dut0: got %b want %b", o0, S0); end n_cmp++;
      @(negedge clk);
      ex_mem_read = 0; ex_reg_write = 1; id_branch = 1;
      #1;
      if (o0 !== S0) begin n_bad++; $display("FAIL b2b_ab dut0: got %b want %b", o0, S0); end n_cmp++;
      @(negedge clk);
      clear_inputs();
      #1;
      if (o0 !== IDLE_V) begin n_bad++; $display("FAIL b2b_done dut0: got %b want %b", o0, IDLE_V); end n_cmp++;
   endtask

   task automatic test_reset_mid_stall();
      @(negedge clk);
      clear_inputs();
      id_branch = 1; id_uses_rt = 1; id_rt = 5'd9; ex_mem_read = 1; ex_dst = 5'd9;
      #1;
      if (o0 !== S1) begin n_bad++; $display("FAIL ms_c1 dut0: got %b want %b", o0, S1); end n_cmp++;
      @(negedge clk);
      #1;
      if (o2 !== S1) begin n_bad++; $display("FAIL ms_c2 dut2: got %b want %b", o2, S1); end n_cmp++;
      #2 rst = 1'b1;
      #1;
      if (o0 !== IDLE_V) begin n_bad++; $display("FAIL ms_rst dut0: got %b want %b", o0, IDLE_V); end n_cmp++;
      if (o2 !== IDLE_V) begin n_bad++; $display("FAIL ms_rst dut2: got %b want %b", o2, IDLE_V); end n_cmp++;
      @(negedge clk);
      clear_inputs();
      rst = 1'b0;
      #1;
      if (o2 !== IDLE_V) begin n_bad++; $display("FAIL ms_release dut2: got %b want %b", o2, IDLE_V); end n_cmp++;
      @(negedge clk);
      ex_mem_read = 1; ex_dst = 5'd8; id_rs = 5'd8; id_uses_rs = 1;
      #1;
      if (o0 !== S0) begin n_bad++; $display("FAIL ms_resume dut0: got %b want %b", o0, S0); end n_cmp++;
      @(negedge clk);
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_load_branch();
      test_alu_mem_branch();
      test_unused_source();
      test_back_to_back();
      test_reset_mid_stall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Parametrised multi-cycle hazard detection unit for the 5-stage pipeline; decodes load-use, ALU-to-branch, load-to-branch and MEM-load-to-branch hazards for the instruction in ID.
- Holds PC and IF/ID frozen, injecting ID/EX bubbles, for a programmable number of cycles using an explicit stall-remaining counter.
- Generates the IF/ID flush for taken branches resolved in ID.

Parameters:
REG_ADDR_W, 5, register-address width
CNT_W, 2, width of stall-remaining counter
LOAD_USE_STALLS, 1, bubbles for EX-load -> ID consumer (0 disables check)
ALU_BRANCH_STALLS, 1, bubbles for EX-ALU-writer -> ID branch (0 disables)
LOAD_BRANCH_STALLS, 2, bubbles for EX-load -> ID branch (0 disables)
MEM_LOAD_BRANCH_STALLS, 1, bubbles for MEM-load -> ID branch (0 disables)
ZERO_REG_EXEMPT, 1, when 1 register address 0 never causes a hazard
Legal range for every *_STALLS parameter: 0 .. 2^CNT_W-1.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
id_rs  in  REG_ADDR_W  IF/ID source register 1
id_rt  in  REG_ADDR_W  IF/ID source register 2
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_branch  in  1  ID instruction is a branch
id_branch_taken  in  1  branch condition true (valid only with id_branch)
ex_mem_read  in  1  ID/EX instruction is a load
ex_reg_write  in  1  ID/EX instruction writes a register
ex_dst  in  REG_ADDR_W  ID/EX destination (rt for loads, muxed dst otherwise)
mem_mem_read  in  1  EX/MEM instruction is a load
mem_dst  in  REG_ADDR_W  EX/MEM destination
pc_write  out  1  PC enable
ifid_write  out  1  IF/ID enable
idex_bubble  out  1  zero ID/EX control fields
ifid_flush  out  1  clear IF/ID (taken branch)
stall_active  out  1  stall in progress this cycle
stall_remaining  out  CNT_W  registered bubbles still owed after this cycle

Behaviour:
- Match rule: match(a,x) = (a==x) && !(ZERO_REG_EXEMPT && x==0). src_hit(x) = (id_uses_rs && match(id_rs,x)) || (id_uses_rt && match(id_rt,x)).
- Detection, priority highest first, yielding N:
  - LB: id_branch && ex_mem_read && src_hit(ex_dst) -> N=LOAD_BRANCH_STALLS
  - LU: ex_mem_read && src_hit(ex_dst) -> N=LOAD_USE_STALLS
  - AB: id_branch && ex_reg_write && !ex_mem_read && src_hit(ex_dst) -> N=ALU_BRANCH_STALLS
  - MB: id_branch && mem_mem_read && src_hit(mem_dst) -> N=MEM_LOAD_BRANCH_STALLS
- detect = first hit with N!=0. A hit with N==0 falls through to lower-priority checks.
- Register r (stall_remaining), reset 0; two states: IDLE (r==0), STALL (r!=0).
- stall_active = (r!=0) || (r==0 && detect); combinational, same cycle as detection.
- While stall_active: pc_write=0, ifid_write=0, idex_bubble=1; otherwise 1/1/0.
- Next r:
  - r!=0 -> r-1; detection ignored while r!=0 (ID frozen, EX holds bubbles).
  - r==0 && detect -> N-1.
  - else 0.
- ifid_flush = id_branch && id_branch_taken && !stall_active. Never asserted during a stall; asserted in the first non-stall cycle if the branch is taken.
- Latency: stall response is 0 cycles (combinational); a hazard with N bubbles holds stall_active for exactly N consecutive cycles.
- Reset: async clear of r to 0 at any time, including mid-stall. During and after reset, outputs are pc_write=1, ifid_write=1, idex_bubble=0, stall_active=0, stall_remaining=0; ifid_flush follows its equation.
- No X propagation: uses flags gate the compares, so an unused field holding any value must not stall.

Test Plan:
- LU: ex_mem_read=1, ex_dst=8, id_rs=8, id_uses_rs=1 -> one cycle pc_write=0, idex_bubble=1, stall_remaining=0; next cycle with bubble in EX -> pc_write=1.
- LB: branch id_rt=9, ex_mem_read=1, ex_dst=9, defaults -> stall_active for exactly 2 cycles (stall_remaining 1 then 0) even though EX inputs change to bubble; ifid_flush=0 throughout, then 1 on the third cycle if id_branch_taken=1.
- AB/MB: ALU writer ex_dst=4 vs branch rs=4 -> 1 stall; then mem_mem_read=1, mem_dst=4 alone -> 1 stall; repeat with ex_dst=0, id_rs=0 -> no stall (zero exempt); rerun with ZERO_REG_EXEMPT=0 -> stall.
- Parameter sweep: LOAD_BRANCH_STALLS=3, CNT_W=2 -> 3 bubbles; LOAD_USE_STALLS=0 -> load-use never stalls, AB/MB still checked.
- Unused source: id_uses_rt=0, id_rt=ex_dst=5, load in EX -> no stall.
- Reset mid-stall: assert rst asynchronously while stall_remaining=1 -> outputs return to pc_write=1, stall_remaining=0 immediately without a clock edge; release -> normal detection resumes.
